// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexes NUM_DIGITS hex digits onto one shared
// active-low seven-segment bus. It drives per-digit decimal points and
// blanking, uses a programmable slot length (REFRESH_DIV) and turns all
// anodes off for the first GUARD cycles of each slot to avoid ghosting.
// Latency: an/seg/dp are registered, one clk behind cnt/digit_idx/inputs.
// Backpressure: none; en=0 darkens the display and freezes the scan position.
// Optional build macro SEG_SCAN_LZ_BLANK_EN: leading-zero suppression of
// digits above digit 0, OR'd with blank_mask.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   en                    scan enable
//   digits                4*NUM_DIGITS hex nibbles, digit 0 is rightmost
//   dp_mask, blank_mask   per-digit decimal point / forced blanking
//   an                    active-low anodes, one-hot-low when lit
//   seg, dp               active-low segments {g,f,e,d,c,b,a} and dp
//   digit_idx             digit currently being scanned
//   slot_tick             pulse on the last cycle of each slot
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 0
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            en,
  input  logic [4*NUM_DIGITS-1:0]                         digits,
  input  logic [NUM_DIGITS-1:0]                           dp_mask,
  input  logic [NUM_DIGITS-1:0]                           blank_mask,
  output logic [NUM_DIGITS-1:0]                           an,
  output logic [6:0]                                      seg,
  output logic                                            dp,
  output logic [((NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
  output logic                                            slot_tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         digit_idx_q, digit_idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic                  in_guard;
  logic [3:0]            cur_digit;
  logic                  cur_blank;
  logic [NUM_DIGITS-1:0] lz_blank;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // With no guard interval the comparison would be constant, so elide it.
  generate
    if (GUARD == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
      assign in_guard = (cnt_q < CNT_GUARD);
    end
  endgenerate

  assign slot_tick = en && (cnt_q == CNT_LAST);

  // Prescaler and digit pointer; both hold while en is low.
  always_comb begin
    cnt_d       = cnt_q;
    digit_idx_d = digit_idx_q;
    if (en) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    end
    if (slot_tick) begin
      digit_idx_d = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + IW'(1);
    end
  end

  // Leading-zero suppression: walk down from the top digit while every digit
  // seen so far is zero. Digit 0 is never suppressed.
`ifdef SEG_SCAN_LZ_BLANK_EN
  logic zero_run;
  always_comb begin
    lz_blank = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run    = zero_run & (digits[4*i +: 4] == 4'h0);
      lz_blank[i] = zero_run;
    end
  end
`else
  assign lz_blank = '0;
`endif

  assign cur_digit = digits[{digit_idx_q, 2'b00} +: 4];
  assign cur_blank = blank_mask[digit_idx_q] | lz_blank[digit_idx_q];

  // Blanking clears segments only; the anode and dp still follow the scan.
  always_comb begin
    an_d  = {NUM_DIGITS{1'b1}};
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (en && !in_guard) begin
      an_d  = ~(NUM_DIGITS'(1) << digit_idx_q);
      seg_d = cur_blank ? 7'h7F : hex7(cur_digit);
      dp_d  = ~dp_mask[digit_idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      digit_idx_q <= '0;
      an_q        <= {NUM_DIGITS{1'b1}};
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      digit_idx_q <= digit_idx_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign digit_idx = digit_idx_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: two instances (GUARD=0 and GUARD=1) share the
// same stimulus and are compared every cycle against a position-based model.
module tb_seg_scan_ctrl;
  localparam int N  = 4;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] digits = 16'h0;
  logic [3:0]  dp_mask = 4'h0;
  logic [3:0]  blank_mask = 4'h0;

  logic [1:0][3:0] an_o;
  logic [1:0][6:0] seg_o;
  logic [1:0]      dp_o;
  logic [1:0][1:0] idx_o;
  logic [1:0]      tick_o;

  int checks = 0;
  int errors = 0;

  seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .GUARD(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .digits(digits), .dp_mask(dp_mask),
    .blank_mask(blank_mask), .an(an_o[0]), .seg(seg_o[0]), .dp(dp_o[0]),
    .digit_idx(idx_o[0]), .slot_tick(tick_o[0])
  );

  seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .GUARD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .digits(digits), .dp_mask(dp_mask),
    .blank_mask(blank_mask), .an(an_o[1]), .seg(seg_o[1]), .dp(dp_o[1]),
    .digit_idx(idx_o[1]), .slot_tick(tick_o[1])
  );

  always #5 clk = ~clk;

  logic [6:0] hex_lut [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Model: pos counts enabled cycles since reset; slot and digit follow from
  // plain division. exp_disp holds the registered {an, seg, dp} expectation.
  int         pos [2];
  logic [11:0] exp_disp [2];

  function automatic logic [11:0] model_disp(input int p, input int g);
    int c = p % RD;
    int i = (p / RD) % N;
    logic [3:0] a;
    logic       b;
    logic [6:0] s;
    if (!en || c < g) return 12'hFFF;
    a = 4'hF;
    a[i] = 1'b0;
    b = blank_mask[i];
`ifdef SEG_SCAN_LZ_BLANK_EN
    if (i > 0 && (digits >> (4 * i)) == 16'h0) b = 1'b1;
`endif
    s = b ? 7'h7F : hex_lut[digits[4*i +: 4]];
    return {a, s, ~dp_mask[i]};
  endfunction

  // The guard length of instance d is d.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos[0]      <= 0;
      pos[1]      <= 0;
      exp_disp[0] <= 12'hFFF;
      exp_disp[1] <= 12'hFFF;
    end else begin
      exp_disp[0] <= model_disp(pos[0], 0);
      exp_disp[1] <= model_disp(pos[1], 1);
      if (en) begin
        pos[0] <= pos[0] + 1;
        pos[1] <= pos[1] + 1;
      end
    end
  end

  task automatic test_reset();
    logic [14:0] act;
    rst_n = 1'b0;
    en = 1'b1;
    digits = 16'h1234;
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        act = {an_o[d], seg_o[d], dp_o[d], idx_o[d], tick_o[d]};
        checks++;
        if (act !== {12'hFFF, 2'b00, 1'b0}) begin
          errors++;
          $display("FAIL reset dut%0d: got %h expected %h", d, act, {12'hFFF, 2'b00, 1'b0});
        end
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_scan_1234();
    logic [14:0] act, expv;
    repeat (36) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        act  = {an_o[d], seg_o[d], dp_o[d], idx_o[d], tick_o[d]};
        expv = {exp_disp[d], 2'((pos[d] / RD) % N), en && (pos[d] % RD == RD - 1)};
        checks++;
        if (act !== expv) begin
          errors++;
          $display("FAIL scan_1234 dut%0d pos=%0d: got %h expected %h", d, pos[d], act, expv);
        end
      end
    end
  endtask

  task automatic test_masks();
    logic [14:0] act, expv;
    dp_mask = 4'b0100;
    blank_mask = 4'b0001;
    repeat (20) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        act  = {an_o[d], seg_o[d], dp_o[d], idx_o[d], tick_o[d]};
        expv = {exp_disp[d], 2'((pos[d] / RD) % N), en && (pos[d] % RD == RD - 1)};
        checks++;
        if (act !== expv) begin
          errors++;
          $display("FAIL masks dut%0d pos=%0d: got %h expected %h", d, pos[d], act, expv);
        end
      end
    end
    dp_mask = 4'h0;
    blank_mask = 4'h0;
  endtask

  task automatic test_random();
    logic [14:0] act, expv;
    repeat (120) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        act  = {an_o[d], seg_o[d], dp_o[d], idx_o[d], tick_o[d]};
        expv = {exp_disp[d], 2'((pos[d] / RD) % N), en && (pos[d] % RD == RD - 1)};
        checks++;
        if (act !== expv) begin
          errors++;
          $display("FAIL random dut%0d pos=%0d: got %h expected %h", d, pos[d], act, expv);
        end
      end
      if ($urandom_range(3) == 0) digits = 16'($urandom);
      if ($urandom_range(5) == 0) dp_mask = 4'($urandom);
      if ($urandom_range(5) == 0) blank_mask = 4'($urandom);
      en = ($urandom_range(7) != 0);
    end
    en = 1'b1;
    dp_mask = 4'h0;
    blank_mask = 4'h0;
  endtask

  task automatic test_reset_midslot();
    logic [14:0] act, expv;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    digits = 16'hA7C3;
    repeat (10) @(negedge clk);
    // cnt=2, digit_idx=2 here; assert reset away from any clock edge.
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      act = {an_o[d], seg_o[d], dp_o[d], idx_o[d], tick_o[d]};
      checks++;
      if (act !== {12'hFFF, 2'b00, 1'b0}) begin
        errors++;
        $display("FAIL reset_midslot dut%0d: got %h expected %h", d, act, {12'hFFF, 2'b00, 1'b0});
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        act  = {an_o[d], seg_o[d], dp_o[d], idx_o[d], tick_o[d]};
        expv = {exp_disp[d], 2'((pos[d] / RD) % N), en && (pos[d] % RD == RD - 1)};
        checks++;
        if (act !== expv) begin
          errors++;
          $display("FAIL after_reset dut%0d pos=%0d: got %h expected %h", d, pos[d], act, expv);
        end
      end
    end
  endtask

  task automatic test_en_freeze();
    logic [14:0] act, expv;
    int k = 0;
    while ((pos[0] % (N * RD)) != (3 * RD + 1) && k < 40) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if ((pos[0] % (N * RD)) != (3 * RD + 1)) begin
      errors++;
      $display("FAIL en_freeze_reach: got pos %0d expected slot position %0d", pos[0] % (N * RD), 3 * RD + 1);
    end
    en = 1'b0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        act  = {an_o[d], seg_o[d], dp_o[d], idx_o[d], tick_o[d]};
        expv = {exp_disp[d], 2'((pos[d] / RD) % N), en && (pos[d] % RD == RD - 1)};
        checks++;
        if (act !== expv) begin
          errors++;
          $display("FAIL en_freeze dut%0d cyc=%0d: got %h expected %h", d, c, act, expv);
        end
      end
      if (c == 9) en = 1'b1;
    end
  endtask

  task automatic test_lz();
    logic [14:0] act, expv;
    digits = 16'h0050;
    repeat (20) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        act  = {an_o[d], seg_o[d], dp_o[d], idx_o[d], tick_o[d]};
        expv = {exp_disp[d], 2'((pos[d] / RD) % N), en && (pos[d] % RD == RD - 1)};
        checks++;
        if (act !== expv) begin
          errors++;
          $display("FAIL lz_0050 dut%0d pos=%0d: got %h expected %h", d, pos[d], act, expv);
        end
      end
    end
    digits = 16'h0000;
    repeat (18) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        act  = {an_o[d], seg_o[d], dp_o[d], idx_o[d], tick_o[d]};
        expv = {exp_disp[d], 2'((pos[d] / RD) % N), en && (pos[d] % RD == RD - 1)};
        checks++;
        if (act !== expv) begin
          errors++;
          $display("FAIL lz_0000 dut%0d pos=%0d: got %h expected %h", d, pos[d], act, expv);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_1234();
    test_masks();
    test_random();
    test_reset_midslot();
    test_en_freeze();
    test_lz();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
